// File: rtl/tpu_tile_sequencer_if.sv
// Bundle of host start/done, memory strobes and debug state for tpu_tile_sequencer.
// master = sequencer side, slave = host/memory/bench side.
interface tpu_tile_sequencer_if #(
  parameter int ADDRESSSIZE   = 10,
  parameter int W_ADDRESSSIZE = 2,
  parameter int TILE_BW       = 4
);
  // Handshake: start is a request with no ready; it is taken only while busy=0 and
  // abort=0, and done pulses one cycle at normal completion. Memory strobes are
  // one-way enables with no back-pressure.
  logic                     start;
  logic                     abort;
  logic [TILE_BW-1:0]       num_tiles;
  logic [ADDRESSSIZE-1:0]   ub_base;
  logic [ADDRESSSIZE-1:0]   res_base;
  logic                     busy;
  logic                     done;
  logic                     we_rl;
  logic [W_ADDRESSSIZE-1:0] w_addr;
  logic                     ub_rd_en;
  logic [ADDRESSSIZE-1:0]   ub_rd_addr;
  logic                     din_valid;
  logic                     res_we;
  logic [ADDRESSSIZE-1:0]   res_addr;
  logic [31:0]              perf_cycles;
  logic [2:0]               dbg_state;

  modport master (
    input  start, abort, num_tiles, ub_base, res_base,
    output busy, done, we_rl, w_addr, ub_rd_en, ub_rd_addr, din_valid,
           res_we, res_addr, perf_cycles, dbg_state
  );

  modport slave (
    output start, abort, num_tiles, ub_base, res_base,
    input  busy, done, we_rl, w_addr, ub_rd_en, ub_rd_addr, din_valid,
           res_we, res_addr, perf_cycles, dbg_state
  );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Multi-tile weight-load / row-stream / result-capture sequencer for the systolic array.
// Optional busy-cycle counter enabled by defining TPU_SEQ_PERF_CNT_EN.
module tpu_tile_sequencer #(
  parameter int MATRIX_SIZE   = 32,
  parameter int ADDRESSSIZE   = 10,
  parameter int W_ADDRESSSIZE = 2,
  parameter int TILE_BW       = 4,
  parameter int LATENCY       = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  tpu_tile_sequencer_if.master  bus
);

  localparam int RW = $clog2(MATRIX_SIZE);
  localparam logic [RW-1:0]      R_LAST    = RW'(MATRIX_SIZE - 1);
  localparam logic [LATENCY-1:0] TAIL_MASK = {LATENCY{1'b1}} >> 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                   state, state_n;
  logic [TILE_BW-1:0]       tiles;
  logic [TILE_BW-1:0]       t, t_n;
  logic [TILE_BW:0]         t_inc;
  logic [RW-1:0]            r, r_n;
  logic [ADDRESSSIZE-1:0]   ub_ptr;
  logic [ADDRESSSIZE-1:0]   res_ptr;
  logic [LATENCY-1:0]       sr, sr_shift, sr_n;
  logic                     accept;
  logic                     pending;

  logic                     we_rl_q;
  logic [W_ADDRESSSIZE-1:0] w_addr_q;
  logic                     ub_rd_en_q;
  logic [ADDRESSSIZE-1:0]   ub_rd_addr_q;
  logic                     din_valid_q;
  logic [ADDRESSSIZE-1:0]   res_addr_q;
  logic                     done_q;
  logic                     busy_q;

  generate
    if (LATENCY == 1) begin : g_sr_one
      assign sr_shift = din_valid_q;
    end else begin : g_sr_many
      assign sr_shift = {sr[LATENCY-2:0], din_valid_q};
    end
  endgenerate

  // Rows are still in flight unless only the final stage (the res_we now issuing) is set.
  assign pending = din_valid_q | (|(sr & TAIL_MASK));
  assign t_inc   = {1'b0, t} + (TILE_BW+1)'(1);

  always_comb begin
    state_n = state;
    t_n     = t;
    r_n     = r;
    accept  = 1'b0;
    sr_n    = sr_shift;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          t_n     = '0;
          r_n     = '0;
          state_n = (bus.num_tiles == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        r_n     = '0;
        state_n = STREAM;
      end
      STREAM: begin
        if (r == R_LAST) begin
          state_n = DRAIN;
        end else begin
          r_n = r + RW'(1);
        end
      end
      DRAIN: begin
        if (!pending) begin
          if (t_inc < {1'b0, tiles}) begin
            t_n     = t_inc[TILE_BW-1:0];
            state_n = LOAD_W;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.abort) begin
      state_n = IDLE;
      t_n     = '0;
      r_n     = '0;
      accept  = 1'b0;
      sr_n    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      tiles        <= '0;
      t            <= '0;
      r            <= '0;
      ub_ptr       <= '0;
      res_ptr      <= '0;
      sr           <= '0;
      we_rl_q      <= 1'b0;
      w_addr_q     <= '0;
      ub_rd_en_q   <= 1'b0;
      ub_rd_addr_q <= '0;
      din_valid_q  <= 1'b0;
      res_addr_q   <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state       <= state_n;
      t           <= t_n;
      r           <= r_n;
      sr          <= sr_n;
      we_rl_q     <= (state_n == LOAD_W);
      ub_rd_en_q  <= (state_n == STREAM);
      din_valid_q <= bus.abort ? 1'b0 : ub_rd_en_q;
      done_q      <= (state_n == DONE);
      busy_q      <= (state_n != IDLE);
      if (state_n == LOAD_W) begin
        w_addr_q <= W_ADDRESSSIZE'(t_n);
      end
      // Tiles are contiguous in the unified buffer, so one running pointer covers t*M + r.
      if (state_n == STREAM) begin
        ub_rd_addr_q <= ub_ptr;
        ub_ptr       <= ub_ptr + ADDRESSSIZE'(1);
      end
      if (sr_n[LATENCY-1]) begin
        res_addr_q <= res_ptr;
        res_ptr    <= res_ptr + ADDRESSSIZE'(1);
      end
      if (accept) begin
        tiles   <= bus.num_tiles;
        ub_ptr  <= bus.ub_base;
        res_ptr <= bus.res_base;
      end
    end
  end

`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = 32'd0;
`endif

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.we_rl      = we_rl_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.ub_rd_en   = ub_rd_en_q;
  assign bus.ub_rd_addr = ub_rd_addr_q;
  assign bus.din_valid  = din_valid_q;
  assign bus.res_we     = sr[LATENCY-1];
  assign bus.res_addr   = res_addr_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer with M=4, L=8: cycle-accurate traces checked
// against hand-derived timing windows and address sequences.
module tb_tpu_tile_sequencer;

  localparam int M  = 4;
  localparam int L  = 8;
  localparam int AS = 10;
  localparam int WA = 2;
  localparam int TB = 4;
  localparam int P  = M + L + 2;
  localparam int NT = 128;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  tpu_tile_sequencer_if #(.ADDRESSSIZE(AS), .W_ADDRESSSIZE(WA), .TILE_BW(TB)) bus ();

  tpu_tile_sequencer #(
    .MATRIX_SIZE(M), .ADDRESSSIZE(AS), .W_ADDRESSSIZE(WA), .TILE_BW(TB), .LATENCY(L)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // trace storage; ctl = {we_rl, ub_rd_en, din_valid, res_we, done, busy}
  logic [5:0]    ctl_t  [0:NT-1];
  logic [WA-1:0] wa_t   [0:NT-1];
  logic [AS-1:0] ub_t   [0:NT-1];
  logic [AS-1:0] res_t  [0:NT-1];
  logic [31:0]   perf_t [0:NT-1];
  logic [2:0]    st_t   [0:NT-1];

  // Expected control bits for a run started at cycle 0 with n tiles.
  function automatic logic [5:0] exp_ctl(input int n, input int c);
    logic we, rd, dv, rw, dn, by;
    we = 1'b0; rd = 1'b0; dv = 1'b0; rw = 1'b0; dn = 1'b0; by = 1'b0;
    if (c < 0) return 6'd0;
    if (n == 0) begin
      dn = (c == 1);
      by = (c == 1);
    end else begin
      for (int t = 0; t < n; t++) begin
        int b;
        b = 1 + P * t;
        we |= (c == b);
        rd |= (c >= b + 1 && c <= b + M);
        dv |= (c >= b + 2 && c <= b + M + 1);
        rw |= (c >= b + L + 2 && c <= b + L + M + 1);
      end
      dn = (c == 1 + P * n);
      by = (c >= 1 && c <= 1 + P * n);
    end
    return {we, rd, dv, rw, dn, by};
  endfunction

  // driver: start at cycle 0, optional abort and second start
  task automatic run_trace(input int n, input int ub, input int rb, input int ncyc,
                           input int ab_c, input int rs_c, input int rn, input int rub,
                           input int rrb);
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      ctl_t[c]  = {bus.we_rl, bus.ub_rd_en, bus.din_valid, bus.res_we, bus.done, bus.busy};
      wa_t[c]   = bus.w_addr;
      ub_t[c]   = bus.ub_rd_addr;
      res_t[c]  = bus.res_addr;
      perf_t[c] = bus.perf_cycles;
      st_t[c]   = bus.dbg_state;
      bus.abort = (c == ab_c);
      if (c == 0) begin
        bus.start     = 1'b1;
        bus.num_tiles = TB'(n);
        bus.ub_base   = AS'(ub);
        bus.res_base  = AS'(rb);
      end else if (c == rs_c) begin
        bus.start     = 1'b1;
        bus.num_tiles = TB'(rn);
        bus.ub_base   = AS'(rub);
        bus.res_base  = AS'(rrb);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.num_tiles = '0; bus.ub_base = '0; bus.res_base = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.we_rl, bus.ub_rd_en, bus.din_valid, bus.res_we, bus.done, bus.busy} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b want=000000",
               {bus.we_rl, bus.ub_rd_en, bus.din_valid, bus.res_we, bus.done, bus.busy});
    end
    n_checks++;
    if ({bus.w_addr, bus.ub_rd_addr, bus.res_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr w=%0h ub=%0h res=%0h want 0", bus.w_addr, bus.ub_rd_addr, bus.res_addr);
    end
    n_checks++;
    if (bus.perf_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf got=%0d want=0", bus.perf_cycles);
    end
    n_checks++;
    if (bus.dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%0d want=0", bus.dbg_state);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_tile();
    logic [2:0] st_exp [0:5];
    int         st_cyc [0:5];
    run_trace(1, 'h010, 'h100, 20, -1, -1, 0, 0, 0);
    for (int c = 0; c <= 20; c++) begin
      n_checks++;
      if (ctl_t[c] !== exp_ctl(1, c)) begin
        n_fail++;
        $display("FAIL single_ctl@%0d got=%b want=%b", c, ctl_t[c], exp_ctl(1, c));
      end
    end
    n_checks++;
    if (wa_t[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL single_waddr got=%0d want=0", wa_t[1]);
    end
    for (int i = 0; i < M; i++) begin
      n_checks++;
      if (ub_t[2 + i] !== AS'('h010 + i)) begin
        n_fail++;
        $display("FAIL single_ub@%0d got=%0h want=%0h", 2 + i, ub_t[2 + i], 'h010 + i);
      end
      n_checks++;
      if (res_t[11 + i] !== AS'('h100 + i)) begin
        n_fail++;
        $display("FAIL single_res@%0d got=%0h want=%0h", 11 + i, res_t[11 + i], 'h100 + i);
      end
    end
    st_cyc = '{0, 1, 2, 6, 15, 16};
    st_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (st_t[st_cyc[i]] !== st_exp[i]) begin
        n_fail++;
        $display("FAIL single_state@%0d got=%0d want=%0d", st_cyc[i], st_t[st_cyc[i]], st_exp[i]);
      end
    end
    n_checks++;
`ifdef TPU_SEQ_PERF_CNT_EN
    if (perf_t[17] !== 32'd15) begin
      n_fail++;
      $display("FAIL single_perf got=%0d want=15", perf_t[17]);
    end
`else
    if (perf_t[17] !== 32'd0) begin
      n_fail++;
      $display("FAIL single_perf got=%0d want=0", perf_t[17]);
    end
`endif
  endtask

  task automatic test_three_tiles();
    int pulses;
    run_trace(3, 'h020, 'h200, 46, -1, -1, 0, 0, 0);
    pulses = 0;
    for (int c = 0; c <= 46; c++) begin
      n_checks++;
      if (ctl_t[c] !== exp_ctl(3, c)) begin
        n_fail++;
        $display("FAIL three_ctl@%0d got=%b want=%b", c, ctl_t[c], exp_ctl(3, c));
      end
      if (ctl_t[c][2]) pulses++;
    end
    for (int t = 0; t < 3; t++) begin
      n_checks++;
      if (wa_t[1 + P * t] !== WA'(t)) begin
        n_fail++;
        $display("FAIL three_waddr@%0d got=%0d want=%0d", 1 + P * t, wa_t[1 + P * t], t);
      end
    end
    n_checks++;
    if (ub_t[33] !== AS'('h02B)) begin
      n_fail++;
      $display("FAIL three_last_ub got=%0h want=2b", ub_t[33]);
    end
    n_checks++;
    if (pulses !== 12) begin
      n_fail++;
      $display("FAIL three_res_pulses got=%0d want=12", pulses);
    end
    n_checks++;
    if (ctl_t[43][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL three_done@43 got=%b want=1", ctl_t[43][1]);
    end
    n_checks++;
    if (res_t[42] !== AS'('h20B)) begin
      n_fail++;
      $display("FAIL three_last_res got=%0h want=20b", res_t[42]);
    end
  endtask

  task automatic test_wrap();
    run_trace(5, 'h3FE, 'h3FF, 75, -1, -1, 0, 0, 0);
    for (int c = 0; c <= 75; c++) begin
      n_checks++;
      if (ctl_t[c] !== exp_ctl(5, c)) begin
        n_fail++;
        $display("FAIL wrap_ctl@%0d got=%b want=%b", c, ctl_t[c], exp_ctl(5, c));
      end
    end
    for (int t = 0; t < 5; t++) begin
      n_checks++;
      if (wa_t[1 + P * t] !== WA'(t % 4)) begin
        n_fail++;
        $display("FAIL wrap_waddr tile%0d got=%0d want=%0d", t, wa_t[1 + P * t], t % 4);
      end
      for (int i = 0; i < M; i++) begin
        n_checks++;
        if (ub_t[2 + P * t + i] !== AS'('h3FE + t * M + i)) begin
          n_fail++;
          $display("FAIL wrap_ub t%0d r%0d got=%0h want=%0h", t, i, ub_t[2 + P * t + i],
                   AS'('h3FE + t * M + i));
        end
        n_checks++;
        if (res_t[2 + L + 1 + P * t + i] !== AS'('h3FF + t * M + i)) begin
          n_fail++;
          $display("FAIL wrap_res t%0d r%0d got=%0h want=%0h", t, i,
                   res_t[2 + L + 1 + P * t + i], AS'('h3FF + t * M + i));
        end
      end
    end
    n_checks++;
    if ({ub_t[2], ub_t[3], ub_t[4]} !== {10'h3FE, 10'h3FF, 10'h000}) begin
      n_fail++;
      $display("FAIL wrap_ub_seq got=%0h,%0h,%0h want=3fe,3ff,0", ub_t[2], ub_t[3], ub_t[4]);
    end
    n_checks++;
    if ({res_t[11], res_t[12]} !== {10'h3FF, 10'h000}) begin
      n_fail++;
      $display("FAIL wrap_res_seq got=%0h,%0h want=3ff,0", res_t[11], res_t[12]);
    end
  endtask

  task automatic test_zero_tiles();
    run_trace(0, 'h010, 'h100, 6, -1, -1, 0, 0, 0);
    for (int c = 0; c <= 6; c++) begin
      n_checks++;
      if (ctl_t[c] !== ((c == 1) ? 6'b000011 : 6'b000000)) begin
        n_fail++;
        $display("FAIL zero_ctl@%0d got=%b want=%b", c, ctl_t[c],
                 (c == 1) ? 6'b000011 : 6'b000000);
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] want;
    run_trace(1, 'h010, 'h100, 30, 4, 8, 1, 'h040, 'h180);
    for (int c = 0; c <= 30; c++) begin
      want = ((c <= 4) ? exp_ctl(1, c) : 6'd0) | exp_ctl(1, c - 8);
      n_checks++;
      if (ctl_t[c] !== want) begin
        n_fail++;
        $display("FAIL abort_ctl@%0d got=%b want=%b", c, ctl_t[c], want);
      end
    end
    n_checks++;
    if (st_t[5] !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_state@5 got=%0d want=0", st_t[5]);
    end
    n_checks++;
    if (ub_t[10] !== AS'('h040) || res_t[19] !== AS'('h180)) begin
      n_fail++;
      $display("FAIL abort_restart_addr ub=%0h res=%0h want 40/180", ub_t[10], res_t[19]);
    end
    n_checks++;
`ifdef TPU_SEQ_PERF_CNT_EN
    if (perf_t[7] !== 32'd4) begin
      n_fail++;
      $display("FAIL abort_perf got=%0d want=4", perf_t[7]);
    end
`else
    if (perf_t[7] !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_perf got=%0d want=0", perf_t[7]);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    run_trace(1, 'h010, 'h100, 20, -1, 6, 3, 'h3F0, 'h000);
    for (int c = 0; c <= 20; c++) begin
      n_checks++;
      if (ctl_t[c] !== exp_ctl(1, c)) begin
        n_fail++;
        $display("FAIL busy_start_ctl@%0d got=%b want=%b", c, ctl_t[c], exp_ctl(1, c));
      end
    end
    n_checks++;
    if (ub_t[5] !== AS'('h013) || res_t[14] !== AS'('h103)) begin
      n_fail++;
      $display("FAIL busy_start_addr ub=%0h res=%0h want 13/103", ub_t[5], res_t[14]);
    end
    n_checks++;
`ifdef TPU_SEQ_PERF_CNT_EN
    if (perf_t[17] !== 32'd15) begin
      n_fail++;
      $display("FAIL busy_start_perf got=%0d want=15", perf_t[17]);
    end
`else
    if (perf_t[17] !== 32'd0) begin
      n_fail++;
      $display("FAIL busy_start_perf got=%0d want=0", perf_t[17]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] want;
    run_trace(1, 'h010, 'h100, 48, -1, 16, 2, 'h050, 'h150);
    for (int c = 0; c <= 48; c++) begin
      want = exp_ctl(1, c) | exp_ctl(2, c - 16);
      n_checks++;
      if (ctl_t[c] !== want) begin
        n_fail++;
        $display("FAIL b2b_ctl@%0d got=%b want=%b", c, ctl_t[c], want);
      end
    end
    n_checks++;
    if (wa_t[17 + P] !== 2'd1 || ub_t[18 + P + M - 1] !== AS'('h057)) begin
      n_fail++;
      $display("FAIL b2b_tile1 w=%0d ub=%0h want 1/57", wa_t[17 + P], ub_t[18 + P + M - 1]);
    end
    n_checks++;
    if (res_t[16 + 11] !== AS'('h150)) begin
      n_fail++;
      $display("FAIL b2b_res_first got=%0h want=150", res_t[16 + 11]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_tile();
    test_three_tiles();
    test_wrap();
    test_zero_tiles();
    test_abort();
    test_start_while_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_tile_sequencer.md
# tpu_tile_sequencer

Multi-tile sequencer for the systolic-array datapath. It replaces the free-running 6-bit result counter and fixed-length state counter with one parametrised controller. It sits between the host start/done interface and the unified buffer, weight SRAM, systolic array and result SRAM. For each of `num_tiles` tiles it:
- loads one weight tile,
- streams `MATRIX_SIZE` activation rows,
- writes the matching delayed result rows into the result SRAM,
- then signals completion.

## Interface
Parameters:
- `MATRIX_SIZE`, 32, rows streamed per tile; ≥2.
- `ADDRESSSIZE`, 10, unified-buffer and result-SRAM address width.
- `W_ADDRESSSIZE`, 2, weight-SRAM address width; selects one of 2^W_ADDRESSSIZE weight tiles.
- `TILE_BW`, 4, width of the tile count.
- `LATENCY`, 64, cycles from `din_valid` to the matching result row at the result SRAM input (input skew + array + deskew); ≥1.

Ports:
- `clk` in 1: rising-edge clock.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: launch request; sampled only in IDLE.
- `abort` in 1: synchronous abort; takes priority over all other inputs except `rstn`.
- `num_tiles` in TILE_BW: tiles to process; sampled with `start`.
- `ub_base` in ADDRESSSIZE: first activation row address; sampled with `start`.
- `res_base` in ADDRESSSIZE: first result row address; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse at normal completion.
- `we_rl` out 1: weight reload strobe to the array.
- `w_addr` out W_ADDRESSSIZE: weight-SRAM address.
- `ub_rd_en` out 1: activation row read.
- `ub_rd_addr` out ADDRESSSIZE: unified-buffer read address.
- `din_valid` out 1: data at array input is valid; equals `ub_rd_en` delayed 1 cycle (SRAM read latency).
- `res_we` out 1: result-SRAM write enable.
- `res_addr` out ADDRESSSIZE: result-SRAM write address.
- `perf_cycles` out 32: busy-cycle count (see Configuration).

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE → LOAD_W on `start` with `num_tiles` ≠ 0. The block latches `num_tiles`, `ub_base` and `res_base`, and clears the tile index `t` and the row counters.
- IDLE → DONE on `start` with `num_tiles` = 0. No memory activity occurs.
- LOAD_W, one cycle:
  - `we_rl`=1.
  - `w_addr` = t[W_ADDRESSSIZE-1:0]; tile indices wrap modulo the weight depth.
  - Next state is STREAM.
- STREAM, MATRIX_SIZE cycles:
  - `ub_rd_en`=1.
  - `ub_rd_addr` = ub_base + t·MATRIX_SIZE + r, for r = 0..MATRIX_SIZE-1. Addition is modulo 2^ADDRESSSIZE (wrap, no error).
  - Next state is DRAIN.
- DRAIN: holds until the valid delay line is empty, i.e. the last `res_we` of the tile has issued. Then:
  - → LOAD_W with t+1 if t+1 < num_tiles;
  - otherwise → DONE.
- DONE, one cycle: `done`=1, `busy`=1. Next state is IDLE.
- Result capture:
  - `res_we` = `din_valid` delayed LATENCY cycles through a shift register.
  - `res_addr` = res_base + k, where k counts `res_we` pulses across all tiles. Wraps modulo 2^ADDRESSSIZE.
- `start` in any state other than IDLE is ignored.
- `abort`, in any state:
  - next state is IDLE;
  - delay line and counters are flushed, so the next cycle has `res_we`=0;
  - no `done` pulse;
  - `busy` falls the next cycle.
- `abort` and `start` in the same IDLE cycle: `abort` wins and `start` is dropped.
- Weights are never reloaded while rows are in flight. This is guaranteed by DRAIN.

## Timing
- Reset values: all outputs 0, state IDLE, delay line clear.
- Let cycle 0 be the cycle `start` is sampled. Cycle numbering for tile 0:
  - LOAD_W at cycle 1;
  - STREAM at cycles 2..M+1;
  - `din_valid` at cycles 3..M+2;
  - `res_we` at cycles 3+L..M+2+L.
- Per tile, LOAD_W-to-LOAD_W spacing is M+L+2 cycles.
- DONE occurs the cycle after the last `res_we`. `busy` is 0 the cycle after DONE.
- All outputs are registered.

## Configuration
- `TPU_SEQ_PERF_CNT_EN` defined:
  - `perf_cycles` clears to 0 on an accepted `start`;
  - it increments every cycle `busy`=1 and saturates at 2^32-1;
  - it holds its value in IDLE, including after `abort`.
- `TPU_SEQ_PERF_CNT_EN` undefined: `perf_cycles` is tied to 0 and no counter logic exists.

## Test plan
All scenarios use M=4, L=8, ADDRESSSIZE=10, W_ADDRESSSIZE=2.
- Single tile, `num_tiles`=1, ub_base=0x010, res_base=0x100:
  - `we_rl`@1 with `w_addr`=0;
  - `ub_rd_addr` 0x010..0x013 @2..5;
  - `res_we`@11..14 with `res_addr` 0x100..0x103;
  - `done`@15, `busy` 0 @16.
- Three tiles:
  - LOAD_W @1, 15, 29 with `w_addr` 0,1,2;
  - last `ub_rd_addr` = ub_base+11;
  - 12 `res_we` pulses;
  - `done`@43.
- Wrap, `num_tiles`=5, ub_base=0x3FE, res_base=0x3FF:
  - tile 4 uses `w_addr`=0;
  - `ub_rd_addr` sequence 0x3FE, 0x3FF, 0x000, …;
  - `res_addr` 0x3FF → 0x000.
- Zero tiles: `start` with `num_tiles`=0 → `done`@1, `busy`@1 only, and no `we_rl`, `ub_rd_en` or `res_we`.
- Abort during STREAM at cycle 4:
  - IDLE, `busy`=0 and `res_we`=0 from cycle 5;
  - no `done`;
  - a fresh `start` at cycle 8 runs normally.
- With `TPU_SEQ_PERF_CNT_EN`, single tile → `perf_cycles`=15 after DONE. Also `start` while busy at cycle 6 → ignored, with an identical trace.
